rx_cmd_parser: RTL

Byte-level command framer that sits directly downstream of the RS232 receiver. It consumes each received byte, qualified by the receiver's one-cycle byte strobe, and assembles fixed 5-byte command frames (SOF, CMD, ARG_HI, ARG_LO, CHK). It verifies the XOR checksum and presents a validated command and 16-bit argument to the bolometer control logic. Malformed or stalled frames are dropped and reported with an error pulse and cause code.

---
 rtl/rx_cmd_parser.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rx_cmd_parser.sv
// ---------------------------------------------------------------------------
// rx_cmd_parser
//
// Byte-level command framer fed by the RS232 receiver. Each received byte is
// qualified by a one-cycle strobe. Bytes are assembled into fixed 5-byte
// frames:
//
//     SOF, CMD, ARG_HI, ARG_LO, CHK     where CHK = CMD ^ ARG_HI ^ ARG_LO
//
// A frame whose checksum matches updates the command/argument outputs and
// pulses cmd_valid_o. A frame with a bad checksum, or one that stalls for
// too long between bytes, is dropped. A dropped frame pulses err_o and
// latches a cause code.
//
// Parameters
//   SOF          start-of-frame byte value
//   TIMEOUT_CYC  maximum clk_i cycles allowed between consecutive bytes of
//                one frame (must be >= 2)
//
// Ports
//   clk_i        in   1   system clock
//   rst_i        in   1   asynchronous, active-high reset
//   rx_data_i    in   8   received byte, valid only while rx_valid_i = 1
//   rx_valid_i   in   1   one-cycle strobe per received byte
//   cmd_o        out  8   last validated command byte (held)
//   arg_o        out  16  last validated argument {ARG_HI, ARG_LO} (held)
//   cmd_valid_o  out  1   one-cycle pulse when cmd_o/arg_o update
//   err_o        out  1   one-cycle pulse when a frame is rejected
//   err_code_o   out  2   cause of last rejection: 01 checksum, 10 timeout
//   busy_o       out  1   high while a frame is in progress
// ---------------------------------------------------------------------------
module rx_cmd_parser #(
    parameter logic [7:0] SOF         = 8'h55,
    parameter int         TIMEOUT_CYC = 10000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  cmd_o,
    output logic [15:0] arg_o,
    output logic        cmd_valid_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic        busy_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    // Counter value at which the next idle cycle ends the frame.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ERR_CHECKSUM = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_AH,
        GET_AL,
        GET_CHK
    } state_t;

    state_t           state_q, state_d;

    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       ah_q, ah_d;
    logic [7:0]       al_q, al_d;
    logic [7:0]       chk_q, chk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0]       cmd_out_d;
    logic [15:0]      arg_out_d;
    logic             cmd_valid_d;
    logic             err_d;
    logic [1:0]       err_code_d;
    logic             busy_d;

    logic             expired;

    // The inter-byte timer runs out only on a cycle with no byte. A byte
    // arriving on the expiry cycle is accepted normally.
    assign expired = (state_q != IDLE) && !rx_valid_i && (cnt_q == CNT_LAST);

    // State register and all registered outputs. Every output is taken
    // straight from a flop, so downstream logic sees glitch-free signals.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            ah_q        <= '0;
            al_q        <= '0;
            chk_q       <= '0;
            cnt_q       <= '0;
            cmd_o       <= '0;
            arg_o       <= '0;
            cmd_valid_o <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= '0;
            busy_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            ah_q        <= ah_d;
            al_q        <= al_d;
            chk_q       <= chk_d;
            cnt_q       <= cnt_d;
            cmd_o       <= cmd_out_d;
            arg_o       <= arg_out_d;
            cmd_valid_o <= cmd_valid_d;
            err_o       <= err_d;
            err_code_o  <= err_code_d;
            busy_o      <= busy_d;
        end
    end

    // Next-state and datapath logic. The checksum is accumulated as the
    // bytes arrive, so the CHK byte needs only a single compare.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        ah_d        = ah_q;
        al_d        = al_q;
        chk_d       = chk_q;
        cnt_d       = cnt_q;
        cmd_out_d   = cmd_o;
        arg_out_d   = arg_o;
        cmd_valid_d = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_o;

        case (state_q)
            IDLE: begin
                // Line noise between frames is silently discarded.
                if (rx_valid_i && (rx_data_i == SOF)) begin
                    state_d = GET_CMD;
                end
            end

            GET_CMD: begin
                if (rx_valid_i) begin
                    cmd_d   = rx_data_i;
                    chk_d   = rx_data_i;
                    state_d = GET_AH;
                end
            end

            GET_AH: begin
                if (rx_valid_i) begin
                    ah_d    = rx_data_i;
                    chk_d   = chk_q ^ rx_data_i;
                    state_d = GET_AL;
                end
            end

            GET_AL: begin
                if (rx_valid_i) begin
                    al_d    = rx_data_i;
                    chk_d   = chk_q ^ rx_data_i;
                    state_d = GET_CHK;
                end
            end

            GET_CHK: begin
                if (rx_valid_i) begin
                    state_d = IDLE;
                    if (rx_data_i == chk_q) begin
                        cmd_out_d   = cmd_q;
                        arg_out_d   = {ah_q, al_q};
                        cmd_valid_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CHECKSUM;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Inter-byte timer. It holds at zero while idle and restarts on
        // every accepted byte. A frame that stalls is abandoned. A new
        // frame can then only start with a fresh SOF.
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (rx_valid_i) begin
            cnt_d = '0;
        end else if (expired) begin
            cnt_d      = '0;
            state_d    = IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // busy_o is registered from the next state. Because of this, it
        // drops in the same cycle that cmd_valid_o or err_o pulses.
        busy_d = (state_d != IDLE);
    end

endmodule
